// File: rtl/hamming_pkg.sv
// Shared constants and state encoding for the (15,11) Hamming transmit sequencer.
package hamming_pkg;

   localparam int unsigned DATA_BITS   = 11;
   localparam int unsigned CODE_BITS   = 15;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned FRAME_CNT_W = 16;
   localparam int unsigned ABORT_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      LOAD    = 3'd2,
      SHIFT   = 3'd3,
      DONE    = 3'd4
   } tx_state_t;

endpackage

// File: rtl/hamming_tx_sequencer_bit_counter.sv
// Bit-index counter with sync clear, enable and a terminal flag at limit-1.
module tx_bit_counter
   import hamming_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cnt_nxt_c,
   output logic         term_c
);

   logic [W-1:0] last_idx_c;

   assign last_idx_c = W'(limit - W'(1));
   assign term_c     = en & (cnt == last_idx_c);

   // Clear wins over increment so a terminal beat restarts the index at zero.
   always_comb begin
      cnt_nxt_c = cnt;
      if (clr)
         cnt_nxt_c = '0;
      else if (en)
         cnt_nxt_c = W'(cnt + W'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else
         cnt <= cnt_nxt_c;
   end

endmodule

// File: rtl/hamming_tx_sequencer.sv
// Handshaked frame sequencer for the (15,11) Hamming transmit datapath.
// Optional frame/abort statistics counters when HAMMING_TX_STATS_EN is defined.
module hamming_tx_sequencer
   import hamming_pkg::*;
(
   input  logic                   CLK,
   input  logic                   REST,
   input  logic                   DEVICE_EN,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   output logic                   IN_SHIFT_EN,
   output logic                   ENC_LOAD,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output logic                   OUT_SHIFT_EN,
   output logic [CNT_W-1:0]       BIT_CNT,
   output logic                   BUSY,
   output logic                   FRAME_DONE
`ifdef HAMMING_TX_STATS_EN
   ,
   output logic [FRAME_CNT_W-1:0] FRAME_CNT,
   output logic [ABORT_CNT_W-1:0] ABORT_CNT
`endif
);

   tx_state_t         state, state_nxt;
   logic              cnt_clr, cnt_en, cnt_term_c;
   logic [CNT_W-1:0]  cnt_limit, cnt_nxt_c;

   assign IN_SHIFT_EN  = IN_VALID & IN_READY;
   assign OUT_SHIFT_EN = OUT_VALID & OUT_READY;

   // Counter steering is kept outside the FSM block so the terminal flag has no loop back into it.
   assign cnt_limit = (state == SHIFT) ? CNT_W'(CODE_BITS) : CNT_W'(DATA_BITS);
   assign cnt_en    = ((state == COLLECT) & DEVICE_EN & IN_SHIFT_EN)
                    | ((state == SHIFT) & OUT_SHIFT_EN);

   tx_bit_counter #(.W(CNT_W)) u_bit_counter (
      .clk       (CLK),
      .rst       (REST),
      .clr       (cnt_clr),
      .en        (cnt_en),
      .limit     (cnt_limit),
      .cnt       (BIT_CNT),
      .cnt_nxt_c (cnt_nxt_c),
      .term_c    (cnt_term_c)
   );

   always_ff @(posedge CLK or posedge REST) begin
      if (REST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (DEVICE_EN)
               state_nxt = COLLECT;
         end
         COLLECT: begin
            // Losing enable mid-collect drops the partial frame.
            if (!DEVICE_EN) begin
               state_nxt = IDLE;
               cnt_clr   = 1'b1;
            end else if (cnt_term_c) begin
               state_nxt = LOAD;
               cnt_clr   = 1'b1;
            end
         end
         LOAD: begin
            cnt_clr   = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            if (cnt_term_c) begin
               state_nxt = DONE;
               cnt_clr   = 1'b1;
            end
         end
         DONE: begin
            cnt_clr   = 1'b1;
            state_nxt = DEVICE_EN ? COLLECT : IDLE;
         end
         default: begin
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // Moore outputs registered from the next state so they align with the state register.
   always_ff @(posedge CLK or posedge REST) begin
      if (REST) begin
         IN_READY   <= 1'b0;
         ENC_LOAD   <= 1'b0;
         OUT_VALID  <= 1'b0;
         FRAME_DONE <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         IN_READY   <= (state_nxt == COLLECT);
         ENC_LOAD   <= (state_nxt == LOAD);
         OUT_VALID  <= (state_nxt == SHIFT);
         FRAME_DONE <= (state_nxt == DONE);
         BUSY       <= ((state_nxt == COLLECT) & (cnt_nxt_c != '0))
                     | (state_nxt == LOAD) | (state_nxt == SHIFT) | (state_nxt == DONE);
      end
   end

`ifdef HAMMING_TX_STATS_EN
   logic abort_c;

   assign abort_c = (state == COLLECT) & ~DEVICE_EN & (BIT_CNT != '0);

   // Frame count wraps; abort count saturates.
   always_ff @(posedge CLK or posedge REST) begin
      if (REST) begin
         FRAME_CNT <= '0;
         ABORT_CNT <= '0;
      end else begin
         if (state == DONE)
            FRAME_CNT <= FRAME_CNT_W'(FRAME_CNT + FRAME_CNT_W'(1));
         if (abort_c && (ABORT_CNT != '1))
            ABORT_CNT <= ABORT_CNT_W'(ABORT_CNT + ABORT_CNT_W'(1));
      end
   end
`endif

endmodule

// File: tb/tb_hamming_tx_sequencer.sv
// Self-checking bench for hamming_tx_sequencer: frame-level reference model plus directed timing checks.
// Stats checks are compiled in when HAMMING_TX_STATS_EN is defined.
module tb_hamming_tx_sequencer;

   logic       CLK = 1'b0;
   logic       REST;
   logic       DEVICE_EN;
   logic       IN_VALID;
   logic       IN_READY;
   logic       IN_SHIFT_EN;
   logic       ENC_LOAD;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic       OUT_SHIFT_EN;
   logic [3:0] BIT_CNT;
   logic       BUSY;
   logic       FRAME_DONE;
`ifdef HAMMING_TX_STATS_EN
   logic [15:0] FRAME_CNT;
   logic [7:0]  ABORT_CNT;
`endif

   hamming_tx_sequencer dut (
      .CLK          (CLK),
      .REST         (REST),
      .DEVICE_EN    (DEVICE_EN),
      .IN_VALID     (IN_VALID),
      .IN_READY     (IN_READY),
      .IN_SHIFT_EN  (IN_SHIFT_EN),
      .ENC_LOAD     (ENC_LOAD),
      .OUT_VALID    (OUT_VALID),
      .OUT_READY    (OUT_READY),
      .OUT_SHIFT_EN (OUT_SHIFT_EN),
      .BIT_CNT      (BIT_CNT),
      .BUSY         (BUSY),
      .FRAME_DONE   (FRAME_DONE)
`ifdef HAMMING_TX_STATS_EN
      ,
      .FRAME_CNT    (FRAME_CNT),
      .ABORT_CNT    (ABORT_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame phase (0 idle, 1 gathering data, 2 encode, 3 sending, 4 finished)
   // plus how many bits of the current phase have been moved.
   int m_ph, m_cnt, m_frames, m_aborts;

   always @(posedge CLK or posedge REST) begin
      if (REST) begin
         m_ph = 0; m_cnt = 0; m_frames = 0; m_aborts = 0;
      end else begin
         case (m_ph)
            0: if (DEVICE_EN) m_ph = 1;
            1: begin
               if (!DEVICE_EN) begin
                  if (m_cnt > 0 && m_aborts < 255) m_aborts++;
                  m_ph = 0; m_cnt = 0;
               end else if (IN_VALID) begin
                  m_cnt++;
                  if (m_cnt == 11) begin m_ph = 2; m_cnt = 0; end
               end
            end
            2: m_ph = 3;
            3: if (OUT_READY) begin
               m_cnt++;
               if (m_cnt == 15) begin m_ph = 4; m_cnt = 0; end
            end
            default: begin
               m_frames++;
               m_ph = DEVICE_EN ? 1 : 0;
            end
         endcase
      end
   end

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge CLK) begin
      if (cmp_en) begin
         check("in_ready",     IN_READY,     (m_ph == 1));
         check("in_shift_en",  IN_SHIFT_EN,  (m_ph == 1) && IN_VALID);
         check("enc_load",     ENC_LOAD,     (m_ph == 2));
         check("out_valid",    OUT_VALID,    (m_ph == 3));
         check("out_shift_en", OUT_SHIFT_EN, (m_ph == 3) && OUT_READY);
         check("frame_done",   FRAME_DONE,   (m_ph == 4));
         check("bit_cnt",      BIT_CNT,      m_cnt);
         check("busy",         BUSY,         (m_ph == 1 && m_cnt > 0) || m_ph >= 2);
`ifdef HAMMING_TX_STATS_EN
         check("frame_cnt",    FRAME_CNT,    m_frames & 32'hFFFF);
         check("abort_cnt",    ABORT_CNT,    m_aborts);
`endif
      end
   end

   task automatic pulse_reset();
      @(posedge CLK); #1 REST = 1'b1;
      @(posedge CLK); #1 REST = 1'b0;
   endtask

   initial begin
      int  load_c, done_c, in_p, out_p, acc, cnt_seen, k;
      bit  ok, rdy29, seen;

      REST = 1'b1; DEVICE_EN = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
      repeat (3) @(posedge CLK);
      #1 REST = 1'b0;
      cmp_en = 1'b1;

      @(negedge CLK);
      check("rst_bit_cnt",  BIT_CNT,  0);
      check("rst_in_ready", IN_READY, 0);
      check("rst_busy",     BUSY,     0);

      // Continuous flow: cycle 1 is the first COLLECT cycle.
      @(posedge CLK); #1 DEVICE_EN = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
      load_c = -1; done_c = -1; in_p = 0; out_p = 0; rdy29 = 1'b0;
      for (int c = 0; c <= 29; c++) begin
         @(negedge CLK);
         if (IN_SHIFT_EN && c <= 28) in_p++;
         if (OUT_SHIFT_EN) out_p++;
         if (ENC_LOAD && load_c < 0) load_c = c;
         if (FRAME_DONE && done_c < 0) done_c = c;
         if (c == 29) rdy29 = IN_READY;
      end
      check("flow_in_pulses",  in_p,   11);
      check("flow_load_cycle", load_c, 12);
      check("flow_out_pulses", out_p,  15);
      check("flow_done_cycle", done_c, 28);
      check("flow_ready_c29",  rdy29,  1);

      // IN_VALID toggling: load only after the 11th accepted bit.
      DEVICE_EN = 1'b0;
      pulse_reset();
      #1 DEVICE_EN = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
      acc = 0; seen = 1'b0;
      for (int c = 0; c < 80 && !seen; c++) begin
         @(posedge CLK); #1 IN_VALID = ~IN_VALID;
         @(negedge CLK);
         if (IN_SHIFT_EN) acc++;
         if (ENC_LOAD) seen = 1'b1;
      end
      check("toggle_load_seen", seen, 1);
      check("toggle_accepts",   acc,  11);

      // Output stall of 5 cycles at BIT_CNT=7.
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge CLK);
         ok = OUT_VALID && (BIT_CNT == 4'd6);
      end
      check("wait_shift6", ok, 1);
      @(posedge CLK); #1 OUT_READY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("stall_out_valid", OUT_VALID,    1);
         check("stall_bit_cnt",   BIT_CNT,      7);
         check("stall_no_shift",  OUT_SHIFT_EN, 0);
      end
      @(posedge CLK); #1 OUT_READY = 1'b1;
      k = 0; seen = 1'b0;
      for (int i = 1; i < 40 && !seen; i++) begin
         @(negedge CLK);
         if (FRAME_DONE) begin seen = 1'b1; k = i; end
      end
      check("stall_done_delay", k, 9);

      // Abort in COLLECT at BIT_CNT=6.
      DEVICE_EN = 1'b0;
      pulse_reset();
      #1 DEVICE_EN = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge CLK);
         ok = IN_READY && (BIT_CNT == 4'd6);
      end
      check("wait_collect6", ok, 1);
      #1 DEVICE_EN = 1'b0;
      @(negedge CLK);
      check("abort_in_ready", IN_READY, 0);
      check("abort_bit_cnt",  BIT_CNT,  0);
      check("abort_busy",     BUSY,     0);
`ifdef HAMMING_TX_STATS_EN
      check("abort_cnt_one",  ABORT_CNT, 1);
`endif
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (ENC_LOAD) acc++;
      end
      check("abort_no_load", acc, 0);

      // DEVICE_EN dropped in SHIFT: frame still completes, then idle.
      @(posedge CLK); #1 DEVICE_EN = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge CLK);
         ok = OUT_VALID;
      end
      check("wait_shift", ok, 1);
      out_p = OUT_SHIFT_EN ? 1 : 0;
      #1 DEVICE_EN = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge CLK);
         if (OUT_SHIFT_EN) out_p++;
         if (FRAME_DONE) seen = 1'b1;
      end
      check("drop_shift_bits", out_p, 15);
      @(negedge CLK);
      check("drop_idle_ready", IN_READY, 0);
      check("drop_idle_busy",  BUSY,     0);

      // Asynchronous reset at BIT_CNT=9 in SHIFT.
      @(posedge CLK); #1 DEVICE_EN = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge CLK);
         ok = OUT_VALID && (BIT_CNT == 4'd9);
      end
      check("wait_shift9", ok, 1);
      #2 REST = 1'b1; DEVICE_EN = 1'b0;
      #1;
      check("arst_out_valid", OUT_VALID,    0);
      check("arst_out_shift", OUT_SHIFT_EN, 0);
      check("arst_bit_cnt",   BIT_CNT,      0);
      check("arst_busy",      BUSY,         0);
      check("arst_in_ready",  IN_READY,     0);
      @(posedge CLK); #1 REST = 1'b0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (ENC_LOAD || OUT_SHIFT_EN || IN_READY || FRAME_DONE) acc++;
      end
      check("arst_no_stray", acc, 0);

`ifdef HAMMING_TX_STATS_EN
      // Three full frames counted.
      pulse_reset();
      #1 DEVICE_EN = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
      acc = 0;
      for (int i = 0; i < 200 && acc < 3; i++) begin
         @(negedge CLK);
         if (FRAME_DONE) acc++;
      end
      check("stats_three_done", acc, 3);
      @(negedge CLK);
      check("stats_frame_cnt3", FRAME_CNT, 3);
`endif

      // Randomized traffic against the model.
      DEVICE_EN = 1'b0;
      pulse_reset();
      for (int c = 0; c < 4000; c++) begin
         @(posedge CLK); #1;
         DEVICE_EN = ($urandom_range(0, 99) < 96);
         IN_VALID  = ($urandom_range(0, 3) != 0);
         OUT_READY = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 999) == 0) begin
            REST = 1'b1;
            @(posedge CLK); #1 REST = 1'b0;
         end
      end
      @(negedge CLK);
      cnt_seen = m_frames;
      check("rand_frames_progress", (cnt_seen > 20), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
